// File: rtl/data_memory_write_unit.sv
// -----------------------------------------------------------------------------
// data_memory_write_unit
//
// MEM-stage store engine. Takes SB/SH/SW stores from the pipeline, aligns the
// write data onto byte lanes, generates byte enables and issues one or two
// word-aligned beats on a req/ack data-memory bus. A store whose bytes spill
// past the end of the addressed word is split into a second beat at the next
// word address. The pipeline is stalled until the last beat is accepted.
//
// Ports:
//   clk          in   clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   mem_write    in   MEM-stage instruction is a store (held while stall=1)
//   store_funct3 in   3'b000 SB, 3'b001 SH, 3'b010 SW, others invalid
//   alu_result   in   store byte address
//   write_data   in   rs2 value, low bytes used for SB/SH
//   bus_req      out  beat valid (registered)
//   bus_addr     out  word-aligned beat address (registered)
//   bus_wdata    out  lane-aligned write data (registered)
//   bus_be       out  byte enables, bit i = lane i (registered)
//   bus_ack      in   beat accepted when bus_req & bus_ack
//   stall        out  combinational pipeline freeze
//   store_fault  out  one-cycle pulse after an invalid-funct3 store
// -----------------------------------------------------------------------------
module data_memory_write_unit #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mem_write,
    input  logic [2:0]            store_funct3,
    input  logic [ADDR_WIDTH-1:0] alu_result,
    input  logic [31:0]           write_data,
    output logic                  bus_req,
    output logic [ADDR_WIDTH-1:0] bus_addr,
    output logic [31:0]           bus_wdata,
    output logic [3:0]            bus_be,
    input  logic                  bus_ack,
    output logic                  stall,
    output logic                  store_fault
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT1 = 2'd1,
        BEAT2 = 2'd2
    } state_t;

    state_t state_reg, state_next;

    logic                  bus_req_reg;
    logic [ADDR_WIDTH-1:0] bus_addr_reg;
    logic [31:0]           bus_wdata_reg;
    logic [3:0]            bus_be_reg;
    logic                  store_fault_reg;
    logic [3:0]            hi_be_reg;    // enables for the spill-over beat
    logic [31:0]           hi_data_reg;  // data for the spill-over beat

    // ------------------------------------------------------------------
    // Store decode and alignment
    // ------------------------------------------------------------------
    logic        funct3_valid;
    logic [3:0]  size_mask;      // one bit per byte of the store, unshifted
    logic [1:0]  offset;
    logic [31:0] data_masked;
    logic [7:0]  be64;
    logic [63:0] d64;
    logic        start;
    logic        split;

    always_comb begin
        funct3_valid = 1'b1;
        size_mask    = 4'b0000;
        case (store_funct3)
            3'b000:  size_mask = 4'b0001;
            3'b001:  size_mask = 4'b0011;
            3'b010:  size_mask = 4'b1111;
            default: funct3_valid = 1'b0;
        endcase
    end

    // Keep only the bytes the store actually writes.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane_mask
        assign data_masked[8*gi +: 8] = size_mask[gi] ? write_data[8*gi +: 8] : 8'h00;
    end

    assign offset = alu_result[1:0];
    // 64-bit views span the addressed word plus the next one; the upper half
    // is non-zero exactly when the store crosses the word boundary.
    assign be64   = {4'b0000, size_mask} << offset;
    assign d64    = {32'h0, data_masked} << {offset, 3'b000};
    assign start  = mem_write & funct3_valid;
    assign split  = |hi_be_reg;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start)   state_next = BEAT1;
            BEAT1:   if (bus_ack) state_next = split ? BEAT2 : IDLE;
            BEAT2:   if (bus_ack) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs (stall). Held low during reset so the pipeline is not
    // frozen by a stale mem_write while the unit is being cleared.
    // ------------------------------------------------------------------
    always_comb begin
        stall = 1'b0;
        case (state_reg)
            IDLE:    stall = start;
            BEAT1:   stall = ~(bus_ack & ~split);
            BEAT2:   stall = ~bus_ack;
            default: stall = 1'b0;
        endcase
        if (!rst_n) begin
            stall = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Registered bus outputs and second-beat latches
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_req_reg     <= 1'b0;
            bus_addr_reg    <= '0;
            bus_wdata_reg   <= 32'h0;
            bus_be_reg      <= 4'b0000;
            hi_be_reg       <= 4'b0000;
            hi_data_reg     <= 32'h0;
            store_fault_reg <= 1'b0;
        end else begin
            store_fault_reg <= (state_reg == IDLE) & mem_write & ~funct3_valid;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        bus_req_reg   <= 1'b1;
                        bus_addr_reg  <= {alu_result[ADDR_WIDTH-1:2], 2'b00};
                        bus_be_reg    <= be64[3:0];
                        bus_wdata_reg <= d64[31:0];
                        hi_be_reg     <= be64[7:4];
                        hi_data_reg   <= d64[63:32];
                    end
                end
                BEAT1: begin
                    if (bus_ack) begin
                        if (split) begin
                            // Next word; wraps naturally at the top of the space.
                            bus_addr_reg  <= bus_addr_reg + ADDR_WIDTH'(4);
                            bus_be_reg    <= hi_be_reg;
                            bus_wdata_reg <= hi_data_reg;
                        end else begin
                            bus_req_reg <= 1'b0;
                            bus_be_reg  <= 4'b0000;
                        end
                    end
                end
                BEAT2: begin
                    if (bus_ack) begin
                        bus_req_reg <= 1'b0;
                        bus_be_reg  <= 4'b0000;
                    end
                end
                default: begin
                    bus_req_reg <= 1'b0;
                    bus_be_reg  <= 4'b0000;
                end
            endcase
        end
    end

    assign bus_req     = bus_req_reg;
    assign bus_addr    = bus_addr_reg;
    assign bus_wdata   = bus_wdata_reg;
    assign bus_be      = bus_be_reg;
    assign store_fault = store_fault_reg;

endmodule
